// File: rtl/fxp_au_seq.sv
// Sequential unsigned fixed-point ADD/SUB/MUL/MAX with valid/ready handshakes and an iterative shift-add MUL.
// Define FXP_AU_SATURATE_EN to saturate on overflow instead of wrapping.
module fxp_au_seq #(
  parameter int unsigned WIDTH_1 = 4,
  parameter int unsigned WIDTH_2 = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_1-1:0] x_int,
  input  logic [WIDTH_2-1:0] x_frac,
  input  logic [WIDTH_1-1:0] y_int,
  input  logic [WIDTH_2-1:0] y_frac,
  input  logic [1:0]         operation,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_1-1:0] result_int,
  output logic [WIDTH_2-1:0] result_frac,
  output logic               zero,
  output logic               overflow
);

  localparam int unsigned W  = WIDTH_1 + WIDTH_2;
  localparam int unsigned W2 = 2 * W;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
`ifdef FXP_AU_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_MAX = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [W2-1:0]   mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [W2-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    res_q, res_d;
  logic            ov_q, ov_d;
  logic            zero_q, zero_d;
  logic            ovf_q, ovf_d;

  logic [W-1:0]    x_op, y_op;
  logic [W:0]      sum;
  logic [W-1:0]    alu_res;
  logic            alu_ovf;
  logic [W2-1:0]   acc_step;
  logic [W-1:0]    mul_res;
  logic            mul_ovf;
  logic            accept;

  assign x_op     = {x_int, x_frac};
  assign y_op     = {y_int, y_frac};
  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  // Single-cycle ADD/SUB/MAX datapath
  always_comb begin
    sum     = {1'b0, x_op} + {1'b0, y_op};
    alu_res = '0;
    alu_ovf = 1'b0;
    case (operation)
      OP_ADD: begin
        alu_ovf = sum[W];
        alu_res = (SAT_EN && alu_ovf) ? '1 : sum[W-1:0];
      end
      OP_SUB: begin
        alu_ovf = (x_op < y_op);
        alu_res = (SAT_EN && alu_ovf) ? '0 : (x_op - y_op);
      end
      OP_MAX: alu_res = (x_op >= y_op) ? x_op : y_op;
      default: alu_res = '0;
    endcase
  end

  // One shift-add step; the multiplier is consumed LSB first
  always_comb begin
    acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
    mul_ovf  = |acc_step[W2-1:W+WIDTH_2];
    mul_res  = (SAT_EN && mul_ovf) ? '1 : acc_step[WIDTH_2 +: W];
  end

  // Next-state and next-register values
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    ov_d     = ov_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          res_d   = mul_res;
          ovf_d   = mul_ovf;
          zero_d  = (mul_res == '0);
          ov_d    = 1'b1;
          state_d = DONE;
        end
      end
      IDLE, DONE: begin
        if (accept) begin
          if (operation == OP_MUL) begin
            mcand_d  = W2'(x_op);
            mplier_d = y_op;
            acc_d    = '0;
            cnt_d    = '0;
            ov_d     = 1'b0;
            state_d  = BUSY;
          end else begin
            res_d   = alu_res;
            ovf_d   = alu_ovf;
            zero_d  = (alu_res == '0);
            ov_d    = 1'b1;
            state_d = DONE;
          end
        end else if (state_q == DONE && out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      ov_q     <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      ov_q     <= ov_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_valid   = ov_q;
  assign zero        = zero_q;
  assign overflow    = ovf_q;
  assign result_int  = res_q[W-1:WIDTH_2];
  assign result_frac = res_q[WIDTH_2-1:0];

endmodule

// File: tb/tb_fxp_au_seq.sv
// Directed bench for fxp_au_seq (default Q4.4); expectations follow FXP_AU_SATURATE_EN when defined.
module tb_fxp_au_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] x_int, x_frac, y_int, y_frac;
  logic [1:0] operation;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] result_int, result_frac;
  logic       zero;
  logic       overflow;

  int n_chk = 0;
  int n_err = 0;

  fxp_au_seq #(.WIDTH_1(4), .WIDTH_2(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x_int      (x_int),
    .x_frac     (x_frac),
    .y_int      (y_int),
    .y_frac     (y_frac),
    .operation  (operation),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result_int (result_int),
    .result_frac(result_frac),
    .zero       (zero),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
    operation = op;
    x_int     = x[7:4];
    x_frac    = x[3:0];
    y_int     = y[7:4];
    y_frac    = y[3:0];
    in_valid  = 1'b1;
  endtask

  // Checks a result held in the output registers
  task automatic check_res(input string tag, input logic [7:0] r, input logic z, input logic o);
    check({tag, "_valid"}, 8'(out_valid), 8'h01);
    check({tag, "_res"}, {result_int, result_frac}, r);
    check({tag, "_zero"}, 8'(zero), 8'(z));
    check({tag, "_ovf"}, 8'(overflow), 8'(o));
  endtask

  // Issues a MUL with out_ready high and checks it completes on the 8th edge
  task automatic run_mul(input string tag, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] r, input logic o);
    drive(2'b10, x, y);
    check({tag, "_acc_rdy"}, 8'(in_ready), 8'h01);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check({tag, "_busy_rdy"}, 8'(in_ready), 8'h00);
      check({tag, "_busy_vld"}, 8'(out_valid), 8'h00);
      tick();
    end
    check_res(tag, r, (r == 8'h00), o);
    tick();
    check({tag, "_drain"}, 8'(out_valid), 8'h00);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    operation = 2'b00;
    x_int = '0; x_frac = '0; y_int = '0; y_frac = '0;
    #12;
    check("rst_valid", 8'(out_valid), 8'h00);
    check("rst_res", {result_int, result_frac}, 8'h00);
    check("rst_zero", 8'(zero), 8'h00);
    check("rst_ovf", 8'(overflow), 8'h00);
    rst_n = 1'b1;
    #1;
    check("rst_rdy", 8'(in_ready), 8'h01);
    tick();

    // ADD 3.5 + 2.25 = 5.75
    out_ready = 1'b1;
    drive(2'b00, 8'h38, 8'h24);
    tick();
    in_valid = 1'b0;
    check_res("add", 8'h5C, 1'b0, 1'b0);
    tick();
    check("add_drain", 8'(out_valid), 8'h00);

    // MUL 2.5 * 3.0 = 7.5
    run_mul("mul", 8'h28, 8'h30, 8'h78, 1'b0);
`ifdef FXP_AU_SATURATE_EN
    run_mul("mul_ovf", 8'hF0, 8'h20, 8'hFF, 1'b1);
`else
    run_mul("mul_ovf", 8'hF0, 8'h20, 8'hE0, 1'b1);
`endif

    // ADD overflow: 15.9375 + 0.0625
    drive(2'b00, 8'hFF, 8'h01);
    tick();
    in_valid = 1'b0;
`ifdef FXP_AU_SATURATE_EN
    check_res("add_ovf", 8'hFF, 1'b0, 1'b1);
`else
    check_res("add_ovf", 8'h00, 1'b1, 1'b1);
`endif

    // SUB underflow 1.0 - 2.0, issued back-to-back from DONE
    drive(2'b01, 8'h10, 8'h20);
    tick();
`ifdef FXP_AU_SATURATE_EN
    check_res("sub_ovf", 8'h00, 1'b1, 1'b1);
`else
    check_res("sub_ovf", 8'hF0, 1'b0, 1'b1);
`endif

    // MAX(1.5, 1.25), back-to-back
    drive(2'b11, 8'h18, 8'h14);
    tick();
    in_valid = 1'b0;
    check_res("max", 8'h18, 1'b0, 1'b0);
    tick();
    check("max_drain", 8'(out_valid), 8'h00);

    // Backpressure: 1.0 + 1.0 held while a pending ADD waits
    out_ready = 1'b0;
    drive(2'b00, 8'h10, 8'h10);
    tick();
    drive(2'b00, 8'h11, 8'h22);
    for (int i = 0; i < 5; i++) begin
      check_res("hold", 8'h20, 1'b0, 1'b0);
      check("hold_rdy", 8'(in_ready), 8'h00);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("hand_rdy", 8'(in_ready), 8'h01);
    tick();
    in_valid = 1'b0;
    check_res("b2b", 8'h33, 1'b0, 1'b0);
    tick();
    check("b2b_drain", 8'(out_valid), 8'h00);

    // Reset during the 4th BUSY cycle of a MUL
    drive(2'b10, 8'h28, 8'h30);
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_valid", 8'(out_valid), 8'h00);
    check("mrst_res", {result_int, result_frac}, 8'h00);
    check("mrst_zero", 8'(zero), 8'h00);
    check("mrst_ovf", 8'(overflow), 8'h00);
    tick();
    #2;
    rst_n = 1'b1;
    #1;
    check("mrst_rdy", 8'(in_ready), 8'h01);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("no_stale", 8'(out_valid), 8'h00);
    end

    // Fresh ADD 1.0 + 0.5 after reset
    drive(2'b00, 8'h10, 8'h08);
    tick();
    in_valid = 1'b0;
    check_res("post_rst", 8'h18, 1'b0, 1'b0);
    tick();
    check("post_drain", 8'(out_valid), 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fxp_au_seq.md
# fxp_au_seq

Sequential, parametrised unsigned fixed-point arithmetic unit: the handshaked, multi-cycle successor of the combinational `au`. It supports ADD, SUB, MUL and MAX on Q(WIDTH_1.WIDTH_2) operands. MUL uses an iterative shift-add datapath. The block sits between an operand producer and a result consumer, with valid/ready on both sides and a registered output that holds until it is accepted.

## Interface
- WIDTH_1, 4: integer-part width (≥1)
- WIDTH_2, 4: fraction-part width (≥1); W = WIDTH_1+WIDTH_2
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands/op valid
- in_ready  out  1  block can accept operands this cycle
- x_int, y_int  in  WIDTH_1  operand integer parts
- x_frac, y_frac  in  WIDTH_2  operand fraction parts
- operation  in  2  00 ADD, 01 SUB (x−y), 10 MUL, 11 MAX
- out_valid  out  1  result registers valid
- out_ready  in  1  consumer accepts result
- result_int  out  WIDTH_1  result integer part
- result_frac  out  WIDTH_2  result fraction part
- zero  out  1  registered result == 0
- overflow  out  1  result exceeded range (carry, borrow, or lost MUL high bits)

## Operation
- States: IDLE, BUSY (MUL iteration), DONE (result held).
- in_ready = (state==IDLE) | (state==DONE & out_ready). Input is accepted on any edge where in_valid & in_ready.
- ADD/SUB/MAX: the result is computed combinationally and loaded into the output registers on the accepting edge; next state is DONE.
- MUL: the accepting edge latches x, y, clears the 2W-bit accumulator and loads bit counter = 0; next state is BUSY. Each BUSY edge adds (x << counter) when y[counter]=1 and increments the counter. The edge that processes bit W−1 loads the output registers; next state is DONE.
- MUL result = product[WIDTH_2 +: W] (truncate toward zero). overflow = |product[2W−1 : W+WIDTH_2].
- ADD: overflow = carry out of W bits. SUB: overflow = (x < y). MAX: overflow = 0.
- zero is evaluated on the final (post-wrap or post-saturation) result.
- DONE: outputs are stable while out_ready=0. On out_ready, go to IDLE, or load the new operation if in_valid is high in the same cycle (back-to-back).
- operation is sampled only on the accepting edge. Input changes at any other time are ignored.
- Reset (asynchronous, any state including mid-BUSY): state=IDLE, out_valid=0, result_int=0, result_frac=0, zero=0, overflow=0, counter and accumulator cleared. Any in-flight MUL is discarded with no output. in_ready=1 once rst_n is released.

## Timing
- ADD/SUB/MAX: out_valid rises on the accepting edge (1-cycle latency). Sustained throughput is 1 op/cycle when out_ready is held high.
- MUL: out_valid rises on the W-th edge after the accepting edge (8 for the defaults). in_ready=0 throughout BUSY.
- out_valid falls on the edge where out_ready=1 unless a new ADD/SUB/MAX is accepted on that same edge.
- All outputs are registered except in_ready, which is combinational from state and out_ready.

## Configuration
- FXP_AU_SATURATE_EN defined: on overflow, ADD and MUL return all-ones (max representable) and SUB returns 0. overflow is still asserted.
- Undefined: results wrap modulo 2^W. MUL keeps the truncated low bits; SUB returns (x−y) mod 2^W.

## Test plan
- ADD 3.5+2.25 (x=3/8, y=2/4): out_valid on the accepting edge, result 5/12, zero=0, overflow=0.
- MUL 2.5×3.0 (x=2/8, y=3/0): in_ready=0 for 8 cycles, result 7/8, overflow=0. 15.0×2.0: overflow=1; result 14/0 when wrapping, 15/15 with SATURATE_EN.
- ADD 15.9375+0.0625 (15/15 + 0/1): overflow=1. Wrap gives 0/0 with zero=1; SATURATE_EN gives 15/15 with zero=0.
- SUB 1.0−2.0: overflow=1. Wrap gives 15/0; SATURATE_EN gives 0/0 with zero=1. MAX(1.5, 1.25) = 1/8.
- Backpressure: hold out_ready=0 for 5 cycles after a result; outputs stay constant and in_ready=0. Then assert out_ready with in_valid high; the new ADD result appears on the same edge.
- Drop rst_n during the 4th BUSY cycle of a MUL: all outputs go to 0 immediately and no stale result appears. A fresh ADD after release completes normally.
